// File: rtl/button_frontend_if.sv
// Signal bundle between the pad-side button sources and the button front end.
// The master drives the raw buttons and sample tick; the slave returns the cleaned levels and events.
interface button_frontend_if #(
    parameter int NBTN = 7
);
    logic            tick;
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] btn_level;
    logic            any_held;
    logic [NBTN-1:0] press_pulse;
    logic [2:0]      sel_code;
    logic            sel_valid;
    logic            multi;
    logic            release_all;

    modport master (
        output tick, btn_raw,
        input  btn_level, any_held, press_pulse, sel_code, sel_valid, multi, release_all
    );

    modport slave (
        input  tick, btn_raw,
        output btn_level, any_held, press_pulse, sel_code, sel_valid, multi, release_all
    );
endinterface

// File: rtl/button_frontend.sv
// Push-button front end: two-flop synchroniser, tick-sampled debouncer, edge detect
// and a capture FSM that records which button opened the current press cycle.
module button_frontend #(
    parameter int NBTN      = 7,
    parameter int DEB_COUNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    button_frontend_if.slave bus
);
    localparam int            CW       = $clog2(DEB_COUNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_COUNT - 1);

    typedef enum logic {IDLE, HELD} state_t;

    logic [NBTN-1:0] meta_q;
    logic [NBTN-1:0] sync_q;
    logic [NBTN-1:0] level_q;
    logic [NBTN-1:0] level_d;
    logic [NBTN-1:0] lvl_q;
    logic [CW-1:0]   cnt_q [NBTN];
    logic [CW-1:0]   cnt_d [NBTN];
    logic [NBTN-1:0] press;
    logic [2:0]      first_idx;
    logic            many;

    state_t          state_q;
    logic [2:0]      sel_code_q;
    logic            sel_valid_q;
    logic            multi_q;
    logic            release_all_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= '0;
            sync_q  <= '0;
            level_q <= '0;
            lvl_q   <= '0;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            meta_q  <= bus.btn_raw;
            sync_q  <= meta_q;
            level_q <= level_d;
            lvl_q   <= level_q;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Any cycle where the synchronised input agrees with the level restarts the count,
    // so a glitch between ticks throws away the ticks already counted.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NBTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (bus.tick) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign press = level_q & ~lvl_q;
    assign many  = ($countones(press) > 1);

    always_comb begin
        first_idx = '0;
        for (int i = NBTN - 1; i >= 0; i--) begin
            if (press[i]) begin
                first_idx = 3'(i);
            end
        end
    end

    // Selection registers keep their last capture after release until the next press cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            sel_code_q    <= '0;
            sel_valid_q   <= 1'b0;
            multi_q       <= 1'b0;
            release_all_q <= 1'b0;
        end else begin
            release_all_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|press) begin
                        sel_code_q  <= first_idx;
                        sel_valid_q <= 1'b1;
                        multi_q     <= many;
                        state_q     <= HELD;
                    end
                end
                HELD: begin
                    if (|press) begin
                        multi_q <= 1'b1;
                    end else if (level_q == '0) begin
                        release_all_q <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.any_held    = |level_q;
    assign bus.press_pulse = press;
    assign bus.sel_code    = sel_code_q;
    assign bus.sel_valid   = sel_valid_q;
    assign bus.multi       = multi_q;
    assign bus.release_all = release_all_q;
endmodule

// File: tb/tb_button_frontend.sv
// Self-checking bench for button_frontend: scenario tasks plus randomized traffic,
// all checked against an event-level reference model built from the behaviour rules.
module tb_button_frontend;
    localparam int NBTN = 7;
    localparam int DEB  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;
    int   tick_phase = 0;

    button_frontend_if #(.NBTN(NBTN)) bus ();

    button_frontend #(.NBTN(NBTN), .DEB_COUNT(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: sync is the raw value from two edges back; a changed level is
    // accepted once DEB ticks have been seen during one unbroken disagreement run.
    logic [NBTN-1:0] raw_hist [$];
    logic [NBTN-1:0] m_level;
    logic [NBTN-1:0] m_prev;
    int              run_base [NBTN];
    int              tick_total;
    logic            m_held;
    logic [2:0]      m_sel;
    logic            m_valid;
    logic            m_multi;
    logic            m_rel;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_hist.delete();
            m_level    = '0;
            m_prev     = '0;
            tick_total = 0;
            for (int i = 0; i < NBTN; i++) run_base[i] = -1;
            m_held  = 1'b0;
            m_sel   = '0;
            m_valid = 1'b0;
            m_multi = 1'b0;
            m_rel   = 1'b0;
        end else begin
            logic [NBTN-1:0] sync_now;
            logic [NBTN-1:0] pulse_now;
            pulse_now = m_level & ~m_prev;
            sync_now  = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size() - 2] : '0;
            m_rel = 1'b0;
            if (!m_held) begin
                if (pulse_now != '0) begin
                    for (int i = NBTN - 1; i >= 0; i--) if (pulse_now[i]) m_sel = 3'(i);
                    m_valid = 1'b1;
                    m_multi = ($countones(pulse_now) > 1);
                    m_held  = 1'b1;
                end
            end else if (pulse_now != '0) begin
                m_multi = 1'b1;
            end else if (m_level == '0) begin
                m_rel  = 1'b1;
                m_held = 1'b0;
            end
            m_prev     = m_level;
            tick_total = tick_total + int'(bus.tick);
            for (int i = 0; i < NBTN; i++) begin
                if (sync_now[i] != m_level[i]) begin
                    if (run_base[i] < 0) run_base[i] = tick_total - int'(bus.tick);
                    if (tick_total - run_base[i] >= DEB) begin
                        m_level[i]  = sync_now[i];
                        run_base[i] = -1;
                    end
                end else begin
                    run_base[i] = -1;
                end
            end
            raw_hist.push_back(bus.btn_raw);
            if (raw_hist.size() > 3) void'(raw_hist.pop_front());
        end
    end

    logic [20:0] obs;
    logic [20:0] expv;
    assign obs  = {bus.btn_level, bus.press_pulse, bus.sel_code, bus.sel_valid,
                   bus.multi, bus.release_all, bus.any_held};
    assign expv = {m_level, m_level & ~m_prev, m_sel, m_valid, m_multi, m_rel, |m_level};

    // One clock of stimulus; the tick strobe fires every fourth cycle.
    task automatic drive(input logic [NBTN-1:0] raw);
        bus.btn_raw = raw;
        bus.tick    = (tick_phase == 3);
        tick_phase  = (tick_phase + 1) % 4;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.btn_raw = '0;
        bus.tick    = 1'b0;
        rst         = 1'b1;
        for (int c = 0; c < 3; c++) drive('0);
        compared++;
        if (obs !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got %h want %h", obs, 21'h0);
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive('0);
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL reset_idle_model: got %h want %h", obs, expv);
            end
        end
    endtask

    task automatic test_clean_press();
        int pulses;
        logic [NBTN-1:0] pval;
        pulses = 0;
        pval   = '0;
        for (int c = 0; c < int'($urandom_range(0, 3)); c++) drive('0);
        for (int c = 0; c < 20; c++) begin
            drive(7'h08);
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL clean_press_model: got %h want %h", obs, expv);
            end
            if (bus.press_pulse != '0) begin
                pulses++;
                pval = bus.press_pulse;
            end
        end
        compared++;
        if (pulses !== 1 || pval !== 7'h08) begin
            mismatched++;
            $display("[TB] FAIL clean_press_pulse: got %0d pulses value %h want 1 pulse value 08", pulses, pval);
        end
        compared++;
        if ({bus.btn_level, bus.sel_code, bus.sel_valid, bus.multi} !== {7'h08, 3'd3, 1'b1, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL clean_press_capture: got level %h sel %0d valid %b multi %b want 08 3 1 0",
                     bus.btn_level, bus.sel_code, bus.sel_valid, bus.multi);
        end
        for (int c = 0; c < 24; c++) begin
            drive('0);
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL clean_release_model: got %h want %h", obs, expv);
            end
        end
    endtask

    task automatic test_bounce();
        int bounce_pulses;
        int settle_pulses;
        logic [NBTN-1:0] pval;
        bounce_pulses = 0;
        settle_pulses = 0;
        pval          = '0;
        for (int c = 0; c < int'($urandom_range(0, 3)); c++) drive('0);
        for (int c = 0; c < 30; c++) begin
            drive(((c / 3) % 2 == 0) ? 7'h01 : 7'h00);
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL bounce_model: got %h want %h", obs, expv);
            end
            if (bus.press_pulse != '0) bounce_pulses++;
        end
        compared++;
        if (bounce_pulses !== 0) begin
            mismatched++;
            $display("[TB] FAIL bounce_no_pulse: got %0d pulses want 0", bounce_pulses);
        end
        for (int c = 0; c < 20; c++) begin
            drive(7'h01);
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL bounce_settle_model: got %h want %h", obs, expv);
            end
            if (bus.press_pulse != '0) begin
                settle_pulses++;
                pval = bus.press_pulse;
            end
        end
        compared++;
        if (settle_pulses !== 1 || pval !== 7'h01) begin
            mismatched++;
            $display("[TB] FAIL bounce_settle_pulse: got %0d pulses value %h want 1 pulse value 01", settle_pulses, pval);
        end
        for (int c = 0; c < 24; c++) drive('0);
    endtask

    task automatic test_simultaneous();
        int pulses;
        int rels;
        logic [NBTN-1:0] pval;
        logic [NBTN-1:0] prev_level;
        pulses = 0;
        rels   = 0;
        pval   = '0;
        for (int c = 0; c < 20; c++) begin
            drive(7'h24);
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL simul_model: got %h want %h", obs, expv);
            end
            if (bus.press_pulse != '0) begin
                pulses++;
                pval = bus.press_pulse;
            end
        end
        compared++;
        if (pulses !== 1 || pval !== 7'h24 || bus.sel_code !== 3'd2 || bus.multi !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL simul_capture: got pulses %0d value %h sel %0d multi %b want 1 24 2 1",
                     pulses, pval, bus.sel_code, bus.multi);
        end
        prev_level = bus.btn_level;
        for (int c = 0; c < 24; c++) begin
            drive('0);
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL simul_release_model: got %h want %h", obs, expv);
            end
            if (bus.release_all) begin
                rels++;
                compared++;
                if (prev_level !== '0 || bus.any_held !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL simul_release_timing: got prev level %h held %b want 00 0", prev_level, bus.any_held);
                end
            end
            prev_level = bus.btn_level;
        end
        compared++;
        if (rels !== 1) begin
            mismatched++;
            $display("[TB] FAIL simul_release_count: got %0d want 1", rels);
        end
    endtask

    task automatic test_overlap();
        int rels;
        rels = 0;
        for (int c = 0; c < 20; c++) drive(7'h40);
        for (int c = 0; c < 20; c++) begin
            drive(7'h42);
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL overlap_model: got %h want %h", obs, expv);
            end
        end
        compared++;
        if (bus.sel_code !== 3'd6 || bus.multi !== 1'b1 || bus.btn_level !== 7'h42) begin
            mismatched++;
            $display("[TB] FAIL overlap_capture: got sel %0d multi %b level %h want 6 1 42",
                     bus.sel_code, bus.multi, bus.btn_level);
        end
        for (int c = 0; c < 24; c++) begin
            drive(7'h02);
            if (bus.release_all) rels++;
        end
        compared++;
        if (rels !== 0) begin
            mismatched++;
            $display("[TB] FAIL overlap_partial_release: got %0d release pulses want 0", rels);
        end
        for (int c = 0; c < 24; c++) begin
            drive('0);
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL overlap_release_model: got %h want %h", obs, expv);
            end
            if (bus.release_all) rels++;
        end
        compared++;
        if (rels !== 1 || bus.sel_code !== 3'd6 || bus.sel_valid !== 1'b1 || bus.multi !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL overlap_final: got rels %0d sel %0d valid %b multi %b want 1 6 1 1",
                     rels, bus.sel_code, bus.sel_valid, bus.multi);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        logic [NBTN-1:0] pval;
        pulses = 0;
        pval   = '0;
        for (int c = 0; c < 20; c++) drive(7'h01);
        rst = 1'b1;
        #1;
        compared++;
        if (obs !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_immediate: got %h want %h", obs, 21'h0);
        end
        drive(7'h01);
        drive(7'h01);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            drive(7'h01);
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL reset_mid_model: got %h want %h", obs, expv);
            end
            if (bus.press_pulse != '0) begin
                pulses++;
                pval = bus.press_pulse;
            end
        end
        compared++;
        if (pulses !== 1 || pval !== 7'h01 || bus.sel_code !== 3'd0 || bus.sel_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_repress: got pulses %0d value %h sel %0d valid %b want 1 01 0 1",
                     pulses, pval, bus.sel_code, bus.sel_valid);
        end
        for (int c = 0; c < 24; c++) drive('0);
    endtask

    task automatic test_random();
        logic [NBTN-1:0] raw;
        raw = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) raw = NBTN'($urandom & $urandom);
            if ($urandom_range(0, 15) == 0) drive(raw ^ NBTN'(1 << $urandom_range(0, NBTN - 1)));
            else drive(raw);
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL random_model: cycle %0d got %h want %h", c, obs, expv);
            end
        end
        for (int c = 0; c < 30; c++) begin
            drive('0);
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL random_drain_model: got %h want %h", obs, expv);
            end
        end
    endtask

    task automatic test_idle();
        int busy;
        busy = 0;
        rst  = 1'b1;
        drive('0);
        rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            drive('0);
            if ({bus.btn_level, bus.press_pulse, bus.sel_valid, bus.multi, bus.release_all, bus.any_held} != '0)
                busy++;
        end
        compared++;
        if (busy !== 0) begin
            mismatched++;
            $display("[TB] FAIL idle_quiet: got %0d active cycles want 0", busy);
        end
    endtask

    initial begin
        $display("[TB] starting button_frontend bench");
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_overlap();
        test_reset_mid();
        test_random();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
